// File: rtl/shift_add_multiplier.sv
// Sequential signed multiplier: sign-magnitude shift-and-add with early exit
// once the remaining multiplier bits are all zero.
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_data,
    input  logic               shift_en,
    input  logic [WIDTH-1:0]   multiplicand_in,
    input  logic [WIDTH-1:0]   multiplier_in,
    output logic [2*WIDTH-1:0] product,
    output logic               product_sign,
    output logic [2*WIDTH-1:0] product_mag,
    output logic               mult_done,
    output logic               busy
);

    // state  | meaning
    // IDLE   | after reset, waiting for the first load
    // RUN    | one shift-add step per cycle while shift_en is high
    // FIX    | apply sign to the accumulated magnitude, publish result
    // DONE   | result held, mult_done high until next load
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t             state_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [2*WIDTH-1:0] acc_q;
    logic               sign_q;
    logic [2*WIDTH-1:0] product_q;
    logic               product_sign_q;
    logic [2*WIDTH-1:0] product_mag_q;
    logic               done_q;
    logic               busy_q;

    logic [WIDTH-1:0]   mcand_mag_d;
    logic [WIDTH-1:0]   mplier_mag_d;
    logic [2*WIDTH-1:0] acc_sum_d;
    logic [WIDTH-1:0]   mplier_shift_d;
    logic               fix_neg_d;

    // The unsigned WIDTH-bit magnitude holds 2^(WIDTH-1) exactly.
    always_comb begin
        mcand_mag_d    = multiplicand_in[WIDTH-1] ? (~multiplicand_in) + WIDTH'(1)
                                                  : multiplicand_in;
        mplier_mag_d   = multiplier_in[WIDTH-1] ? (~multiplier_in) + WIDTH'(1)
                                                : multiplier_in;
        acc_sum_d      = acc_q + mcand_q;
        mplier_shift_d = mplier_q >> 1;
        fix_neg_d      = sign_q && (acc_q != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            mcand_q        <= '0;
            mplier_q       <= '0;
            acc_q          <= '0;
            sign_q         <= 1'b0;
            product_q      <= '0;
            product_sign_q <= 1'b0;
            product_mag_q  <= '0;
            done_q         <= 1'b0;
            busy_q         <= 1'b0;
        end else if (load_data) begin
            mcand_q  <= {{WIDTH{1'b0}}, mcand_mag_d};
            mplier_q <= mplier_mag_d;
            acc_q    <= '0;
            sign_q   <= multiplicand_in[WIDTH-1] ^ multiplier_in[WIDTH-1];
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= S_RUN;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (shift_en) begin
                        if (mplier_q[0]) begin
                            acc_q <= acc_sum_d;
                        end
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_shift_d;
                        if (mplier_shift_d == '0) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    product_mag_q  <= acc_q;
                    product_sign_q <= fix_neg_d;
                    product_q      <= fix_neg_d ? -acc_q : acc_q;
                    done_q         <= 1'b1;
                    busy_q         <= 1'b0;
                    state_q        <= S_DONE;
                end
                default: ;
            endcase
        end
    end

    assign product      = product_q;
    assign product_sign = product_sign_q;
    assign product_mag  = product_mag_q;
    assign mult_done    = done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Bench for shift_add_multiplier: directed vectors, stall/abort/reset
// sequences and random operands against an arithmetic reference.
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_data;
    logic        shift_en;
    logic [7:0]  multiplicand_in;
    logic [7:0]  multiplier_in;
    logic [15:0] product;
    logic        product_sign;
    logic [15:0] product_mag;
    logic        mult_done;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int cycles;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .load_data       (load_data),
        .shift_en        (shift_en),
        .multiplicand_in (multiplicand_in),
        .multiplier_in   (multiplier_in),
        .product         (product),
        .product_sign    (product_sign),
        .product_mag     (product_mag),
        .mult_done       (mult_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
        logic        sign;
        logic [15:0] mag;
        int          cyc;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulses load with the given operands; returns with load_data low after E0.
    task automatic start(input logic [7:0] a, input logic [7:0] b);
        multiplicand_in = a;
        multiplier_in   = b;
        load_data       = 1'b1;
        tick();
        load_data       = 1'b0;
        cycles          = 0;
    endtask

    task automatic wait_done();
        while (!mult_done && cycles < 60) begin
            tick();
            cycles++;
        end
    endtask

    function automatic int ref_k(input logic [7:0] b);
        int m;
        int k;
        m = b[7] ? 256 - int'(b) : int'(b);
        k = 1;
        for (int i = 0; i < 8; i++) begin
            if (((m >> i) & 1) != 0) k = i + 1;
        end
        return k;
    endfunction

    initial begin
        logic [31:0] p32;
        logic [31:0] m32;
        int          pi;
        int          k;
        logic [7:0]  ra;
        logic [7:0]  rb;

        vecs[0] = '{8'h03, 8'hFB, 16'hFFF1, 1'b1, 16'h000F, 4};
        vecs[1] = '{8'h80, 8'h80, 16'h4000, 1'b0, 16'h4000, 9};
        vecs[2] = '{8'h7F, 8'h7F, 16'h3F01, 1'b0, 16'h3F01, 8};
        vecs[3] = '{8'h81, 8'h7F, 16'hC0FF, 1'b1, 16'h3F01, 8};
        vecs[4] = '{8'h85, 8'h00, 16'h0000, 1'b0, 16'h0000, 2};
        vecs[5] = '{8'h00, 8'hFF, 16'h0000, 1'b0, 16'h0000, 2};

        rst = 1'b1;
        load_data = 1'b0;
        shift_en = 1'b0;
        multiplicand_in = '0;
        multiplier_in = '0;
        repeat (2) tick();
        chk("reset_product", product, 0);
        chk("reset_done", mult_done, 0);
        chk("reset_busy", busy, 0);
        rst = 1'b0;
        tick();

        shift_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            start(vecs[i].a, vecs[i].b);
            chk($sformatf("vec%0d_busy", i), busy, 1);
            wait_done();
            chk($sformatf("vec%0d_cycles", i), cycles, vecs[i].cyc);
            chk($sformatf("vec%0d_product", i), product, vecs[i].prod);
            chk($sformatf("vec%0d_sign", i), product_sign, vecs[i].sign);
            chk($sformatf("vec%0d_mag", i), product_mag, vecs[i].mag);
            chk($sformatf("vec%0d_idle_busy", i), busy, 0);
            repeat (2) tick();
            chk($sformatf("vec%0d_hold", i), mult_done, 1);
        end

        // Stall: three cycles with shift_en low after the first step.
        start(8'h03, 8'hFB);
        tick(); cycles++;
        shift_en = 1'b0;
        repeat (3) begin tick(); cycles++; end
        chk("stall_busy", busy, 1);
        chk("stall_not_done", mult_done, 0);
        chk("stall_old_product", product, 16'h0000);
        shift_en = 1'b1;
        wait_done();
        chk("stall_cycles", cycles, 7);
        chk("stall_product", product, 16'hFFF1);

        // Abort: a new load mid-RUN restarts with the new operands.
        start(8'h03, 8'hFB);
        tick();
        start(8'h02, 8'h02);
        chk("abort_not_done", mult_done, 0);
        chk("abort_old_product", product, 16'hFFF1);
        wait_done();
        chk("abort_cycles", cycles, 3);
        chk("abort_product", product, 16'h0004);
        chk("abort_sign", product_sign, 0);

        // Load and shift in the same cycle: load wins, no step taken.
        multiplicand_in = 8'h05;
        multiplier_in   = 8'h03;
        load_data = 1'b1;
        shift_en  = 1'b1;
        tick();
        load_data = 1'b0;
        cycles = 0;
        wait_done();
        chk("loadshift_cycles", cycles, 3);
        chk("loadshift_product", product, 16'h000F);

        // Asynchronous reset mid-RUN.
        start(8'h7F, 8'h7F);
        repeat (2) tick();
        #2 rst = 1'b1;
        #1;
        chk("arst_product", product, 0);
        chk("arst_mag", product_mag, 0);
        chk("arst_sign", product_sign, 0);
        chk("arst_done", mult_done, 0);
        chk("arst_busy", busy, 0);
        tick();
        rst = 1'b0;
        shift_en = 1'b1;
        repeat (10) tick();
        chk("post_rst_product", product, 0);
        chk("post_rst_done", mult_done, 0);
        chk("post_rst_busy", busy, 0);

        for (int n = 0; n < 40; n++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (n == 0) ra = 8'h80;
            if (n == 1) rb = 8'h01;
            pi  = int'($signed(ra)) * int'($signed(rb));
            p32 = pi;
            m32 = (pi < 0) ? -pi : pi;
            k   = ref_k(rb);
            start(ra, rb);
            wait_done();
            chk($sformatf("rnd%0d_%02h_%02h_cycles", n, ra, rb), cycles, k + 1);
            chk($sformatf("rnd%0d_%02h_%02h_product", n, ra, rb), product, {16'h0, p32[15:0]});
            chk($sformatf("rnd%0d_%02h_%02h_sign", n, ra, rb), product_sign, (pi < 0) ? 1 : 0);
            chk($sformatf("rnd%0d_%02h_%02h_mag", n, ra, rb), product_mag, {16'h0, m32[15:0]});
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
